// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory-bus responder: state encoding, the serial-port
// MMIO window and the status-word layout.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAct,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StIoTxWait,
    StResp
  } bus_state_e;

  localparam logic [15:0] MMIO_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] MMIO_STAT_ADDR = 16'hBF01;

  localparam int unsigned STAT_TX_READY_BIT = 0;
  localparam int unsigned STAT_RX_VALID_BIT = 1;

  function automatic logic [15:0] stat_word(input logic rx_valid, input logic tx_ready);
    logic [15:0] w;
    w = '0;
    w[STAT_TX_READY_BIT] = tx_ready;
    w[STAT_RX_VALID_BIT] = rx_valid;
    return w;
  endfunction

endpackage

// File: rtl/sram_timing_ctrl.sv
// Sequences the asynchronous SRAM pins for one read or write access; all pins registered.
// 'last' is high during the final cycle of an access so the caller can respond on that edge.
module sram_timing_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RD_WAIT_CYC  = 2,
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter logic [1:0]  BANK_SEL     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        last,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_dout_en,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  localparam logic [2:0] RdLoad = 3'(RD_WAIT_CYC - 1);
  localparam logic [2:0] WrLoad = 3'(WR_PULSE_CYC - 1);

  bus_state_e phase_q;
  logic [2:0] cnt_q;

  assign last = ((phase_q == StRdAct) && (cnt_q == 3'd0)) || (phase_q == StWrHold);

  // ram_addr and ram_dout are only reloaded at the start of an access, so they stay
  // stable through it and afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= StIdle;
      cnt_q       <= 3'd0;
      ram_addr    <= '0;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
    end else begin
      unique case (phase_q)
        StIdle: begin
          if (start) begin
            ram_addr <= {BANK_SEL, addr};
            ram_ce_n <= 1'b0;
            if (we) begin
              phase_q     <= StWrSetup;
              ram_dout    <= wdata;
              ram_dout_en <= 1'b1;
            end else begin
              phase_q  <= StRdAct;
              ram_oe_n <= 1'b0;
              cnt_q    <= RdLoad;
            end
          end
        end
        StRdAct: begin
          if (cnt_q == 3'd0) begin
            phase_q  <= StIdle;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StWrSetup: begin
          phase_q  <= StWrPulse;
          ram_we_n <= 1'b0;
          cnt_q    <= WrLoad;
        end
        StWrPulse: begin
          if (cnt_q == 3'd0) begin
            phase_q  <= StWrHold;
            ram_we_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StWrHold: begin
          phase_q     <= StIdle;
          ram_ce_n    <= 1'b1;
          ram_dout_en <= 1'b0;
        end
        default: phase_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Responder end of the CPU memory interface: SRAM accesses plus, when SERIAL_MMIO_EN is
// defined, the serial-port window at 0xBF00 (data) / 0xBF01 (status).
module mem_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RD_WAIT_CYC  = 2,
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter logic [1:0]  BANK_SEL     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_dout_en,
  input  logic [15:0] ram_din,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data,
  output logic        io_rx_pop,
  input  logic        io_tx_ready,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data
);

  bus_state_e state_q;
  logic       we_q;
  logic [7:0] tx_byte_q;
  logic       is_data, is_stat;
  logic       accept, sram_start, sram_last;

`ifdef SERIAL_MMIO_EN
  assign is_data = (req_addr == MMIO_DATA_ADDR);
  assign is_stat = (req_addr == MMIO_STAT_ADDR);
`else
  assign is_data = 1'b0;
  assign is_stat = 1'b0;
`endif

  assign accept     = req_ready && req_valid;
  assign sram_start = accept && !is_data && !is_stat;

  sram_timing_ctrl #(
    .RD_WAIT_CYC (RD_WAIT_CYC),
    .WR_PULSE_CYC(WR_PULSE_CYC),
    .BANK_SEL    (BANK_SEL)
  ) u_sram (
    .clk        (clk),
    .rst        (rst),
    .start      (sram_start),
    .we         (req_we),
    .addr       (req_addr),
    .wdata      (req_wdata),
    .last       (sram_last),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .ram_dout_en(ram_dout_en),
    .ram_ce_n   (ram_ce_n),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      tx_byte_q   <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      io_rx_pop   <= 1'b0;
      io_tx_valid <= 1'b0;
      io_tx_data  <= '0;
    end else begin
      resp_valid  <= 1'b0;
      io_rx_pop   <= 1'b0;
      io_tx_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            tx_byte_q <= req_wdata[7:0];
            if (is_data && req_we) begin
              state_q <= StIoTxWait;
            end else if (is_data) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_rdata <= io_rx_valid ? {8'h00, io_rx_data} : 16'h0000;
              io_rx_pop  <= io_rx_valid;
            end else if (is_stat) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_rdata <= req_we ? 16'h0000 : stat_word(io_rx_valid, io_tx_ready);
            end else begin
              // Pin-level phases are tracked inside u_sram; this records the access kind.
              state_q <= req_we ? StWrSetup : StRdAct;
            end
          end
        end
        StRdAct, StWrSetup, StWrPulse, StWrHold: begin
          if (sram_last) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 16'h0000 : ram_din;
          end
        end
        StIoTxWait: begin
          // The strobe goes out first; the response follows on the next edge.
          if (io_tx_valid) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_rdata <= 16'h0000;
          end else if (io_tx_ready) begin
            io_tx_valid <= 1'b1;
            io_tx_data  <= tx_byte_q;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          req_ready  <= 1'b1;
          resp_rdata <= 16'h0000;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a default-parameter instance and a fast-read /
// long-write instance, each with a small SRAM model, checked against a response scoreboard.
module tb_mem_bus_responder;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv, r_we, sel;
  logic [15:0] r_addr, r_wdata;
  logic        io_rx_valid, io_tx_ready;
  logic [7:0]  io_rx_data;

  logic        rdy_a, rsp_a, dout_en_a, ce_a, oe_a, we_a, pop_a, txv_a;
  logic [15:0] rdata_a, dout_a, din_a;
  logic [17:0] addr_a;
  logic [7:0]  txd_a;
  logic        rdy_b, rsp_b, dout_en_b, ce_b, oe_b, we_b, pop_b, txv_b;
  logic [15:0] rdata_b, dout_b, din_b;
  logic [17:0] addr_b;
  logic [7:0]  txd_b;

  mem_bus_responder dut_a (
    .clk(clk), .rst(rst), .req_valid(rv && !sel), .req_ready(rdy_a), .req_we(r_we),
    .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rsp_a), .resp_rdata(rdata_a),
    .ram_addr(addr_a), .ram_dout(dout_a), .ram_dout_en(dout_en_a), .ram_din(din_a),
    .ram_ce_n(ce_a), .ram_oe_n(oe_a), .ram_we_n(we_a), .io_rx_valid(io_rx_valid),
    .io_rx_data(io_rx_data), .io_rx_pop(pop_a), .io_tx_ready(io_tx_ready),
    .io_tx_valid(txv_a), .io_tx_data(txd_a)
  );

  mem_bus_responder #(.RD_WAIT_CYC(1), .WR_PULSE_CYC(7), .BANK_SEL(2'b10)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv && sel), .req_ready(rdy_b), .req_we(r_we),
    .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rsp_b), .resp_rdata(rdata_b),
    .ram_addr(addr_b), .ram_dout(dout_b), .ram_dout_en(dout_en_b), .ram_din(din_b),
    .ram_ce_n(ce_b), .ram_oe_n(oe_b), .ram_we_n(we_b), .io_rx_valid(io_rx_valid),
    .io_rx_data(io_rx_data), .io_rx_pop(pop_b), .io_tx_ready(io_tx_ready),
    .io_tx_valid(txv_b), .io_tx_data(txd_b)
  );

  // SRAM models: write only when the responder actually drives the bus.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  always @(posedge clk) if (!ce_a && !we_a && dout_en_a) mem_a[addr_a[7:0]] <= dout_a;
  always @(posedge clk) if (!ce_b && !we_b && dout_en_b) mem_b[addr_b[7:0]] <= dout_b;
  assign din_a = (!ce_a && !oe_a) ? mem_a[addr_a[7:0]] : 16'hDEAD;
  assign din_b = (!ce_b && !oe_b) ? mem_b[addr_b[7:0]] : 16'hDEAD;

  int cont_a = 0;
  int cont_b = 0;
  always @(negedge clk) begin
    if (dout_en_a && !oe_a) cont_a <= cont_a + 1;
    if (dout_en_b && !oe_b) cont_b <= cont_b + 1;
  end

  logic        m_rdy, m_rsp, m_ce, m_we, m_pop, m_txv;
  logic [15:0] m_rdata;
  logic [17:0] m_addr;
  logic [7:0]  m_txd;
  always_comb begin
    if (!sel) begin
      m_rdy = rdy_a; m_rsp = rsp_a; m_ce = ce_a; m_we = we_a; m_pop = pop_a;
      m_txv = txv_a; m_rdata = rdata_a; m_addr = addr_a; m_txd = txd_a;
    end else begin
      m_rdy = rdy_b; m_rsp = rsp_b; m_ce = ce_b; m_we = we_b; m_pop = pop_b;
      m_txv = txv_b; m_rdata = rdata_b; m_addr = addr_b; m_txd = txd_b;
    end
  end

  typedef struct {
    logic [15:0] rdata;
    int          lat;
    int          we_low;
  } exp_t;
  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  int          o_wait, o_ce_low, o_pops, o_txs, o_tx_lat;
  logic [7:0]  o_txd;
  logic [17:0] o_addr_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency counts edges from the acceptance edge to the edge that raises resp_valid.
  task automatic do_req(input logic s, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input int exp_lat, input int exp_we_low, input bit hold,
                        input string tag);
    exp_t e;
    int   lat;
    int   we_low;
    bit   got;
    sb_q.push_back('{exp_rdata, exp_lat, exp_we_low});
    sel = s; rv = 1'b1; r_we = we; r_addr = addr; r_wdata = wdata;
    o_wait = 0; o_ce_low = 0; o_pops = 0; o_txs = 0; o_tx_lat = -1; o_txd = '0;
    o_addr_seen = '0;
    while (!m_rdy && o_wait < 100) begin
      @(posedge clk); #1;
      o_wait++;
    end
    @(posedge clk); #1;
    if (!hold) rv = 1'b0;
    lat = 0; we_low = 0; got = 1'b0;
    while (lat < 100) begin
      if (!m_we) we_low++;
      if (!m_ce) begin
        o_ce_low++;
        if (o_ce_low == 1) o_addr_seen = m_addr;
      end
      if (m_pop) o_pops++;
      if (m_txv) begin
        o_txs++;
        o_tx_lat = lat;
        o_txd = m_txd;
      end
      if (m_rsp) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_rdata"}, 32'(m_rdata), 32'(e.rdata));
    chk({tag, "_we_low_cycles"}, we_low, e.we_low);
    chk({tag, "_ce_idle_at_resp"}, 32'(m_ce), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rv = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0; sel = 1'b0;
    io_rx_valid = 1'b0; io_rx_data = '0; io_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(rdy_a), 0);
    chk("rst_resp_valid", 32'(rsp_a), 0);
    chk("rst_resp_rdata", 32'(rdata_a), 0);
    chk("rst_ce_n", 32'(ce_a), 1);
    chk("rst_oe_n", 32'(oe_a), 1);
    chk("rst_we_n", 32'(we_a), 1);
    chk("rst_dout_en", 32'(dout_en_a), 0);
    chk("rst_dout", 32'(dout_a), 0);
    chk("rst_ram_addr", 32'(addr_a), 0);
    chk("rst_io_outputs", {pop_a, txv_a, txd_a}, 0);
    chk("rst_b_ce_n", 32'(ce_b), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(rdy_a), 1);

    do_req(1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 4, 2, 1'b0, "wr_0040");
    chk("wr_0040_ram_addr", 32'(o_addr_seen), 32'({2'b00, 16'h0040}));
    do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2, 0, 1'b0, "rd_0040");

    // Back-to-back with req_valid held through the first access.
    do_req(1'b0, 1'b1, 16'h0123, 16'hA5C3, 16'h0000, 4, 2, 1'b1, "b2b_wr");
    do_req(1'b0, 1'b0, 16'h0123, 16'h0000, 16'hA5C3, 2, 0, 1'b0, "b2b_rd");
    chk("b2b_accept_gap", o_wait, 1);
    do_req(1'b0, 1'b1, 16'h0055, 16'h0001, 16'h0000, 4, 2, 1'b0, "wr_0055");
    do_req(1'b0, 1'b0, 16'h0055, 16'h0000, 16'h0001, 2, 0, 1'b0, "rd_0055");

    do_req(1'b1, 1'b1, 16'h0077, 16'h1357, 16'h0000, 9, 7, 1'b0, "b_wr");
    chk("b_wr_ram_addr", 32'(o_addr_seen), 32'({2'b10, 16'h0077}));
    do_req(1'b1, 1'b0, 16'h0077, 16'h0000, 16'h1357, 1, 0, 1'b0, "b_rd");

`ifdef SERIAL_MMIO_EN
    io_rx_valid = 1'b1; io_rx_data = 8'h5A; io_tx_ready = 1'b1;
    do_req(1'b0, 1'b0, MMIO_STAT_ADDR, 16'h0000, 16'h0003, 0, 0, 1'b0, "stat_txrdy");
    chk("stat_txrdy_ce_low", o_ce_low, 0);
    io_tx_ready = 1'b0;
    do_req(1'b0, 1'b0, MMIO_STAT_ADDR, 16'h0000, 16'h0002, 0, 0, 1'b0, "stat_txbusy");
    do_req(1'b0, 1'b0, MMIO_DATA_ADDR, 16'h0000, 16'h005A, 0, 0, 1'b0, "rx_read");
    chk("rx_read_pops", o_pops, 1);
    chk("rx_read_ce_low", o_ce_low, 0);
    io_rx_valid = 1'b0;
    do_req(1'b0, 1'b0, MMIO_DATA_ADDR, 16'h0000, 16'h0000, 0, 0, 1'b0, "rx_empty");
    chk("rx_empty_pops", o_pops, 0);
    @(posedge clk); #1;
    fork
      do_req(1'b0, 1'b1, MMIO_DATA_ADDR, 16'h1241, 16'h0000, 7, 0, 1'b0, "tx_write");
      begin
        repeat (6) @(posedge clk);
        #1;
        io_tx_ready = 1'b1;
      end
    join
    chk("tx_write_strobes", o_txs, 1);
    chk("tx_write_strobe_lat", o_tx_lat, 6);
    chk("tx_write_data", 32'(o_txd), 32'h41);
    chk("tx_write_ce_low", o_ce_low, 0);
    do_req(1'b0, 1'b1, MMIO_STAT_ADDR, 16'hFFFF, 16'h0000, 0, 0, 1'b0, "stat_write");
    chk("stat_write_strobes", o_txs, 0);
`else
    io_rx_valid = 1'b1; io_rx_data = 8'h5A; io_tx_ready = 1'b1;
    do_req(1'b0, 1'b1, 16'hBF00, 16'h1241, 16'h0000, 4, 2, 1'b0, "bf00_sram_wr");
    chk("bf00_sram_wr_strobes", o_txs, 0);
    chk("bf00_sram_wr_ce_low", o_ce_low, 4);
    do_req(1'b0, 1'b0, 16'hBF00, 16'h0000, 16'h1241, 2, 0, 1'b0, "bf00_sram_rd");
    chk("bf00_sram_rd_pops", o_pops, 0);
`endif

    // Reset in the middle of a write pulse.
    sel = 1'b0; rv = 1'b1; r_we = 1'b1; r_addr = 16'h0010; r_wdata = 16'h1111;
    n = 0;
    while (!rdy_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    rv = 1'b0;
    n = 0;
    while (we_a !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid_reached_pulse", 32'(we_a), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_we_n", 32'(we_a), 1);
    chk("rst_mid_ce_n", 32'(ce_a), 1);
    chk("rst_mid_dout_en", 32'(dout_en_a), 0);
    chk("rst_mid_req_ready", 32'(rdy_a), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready_after", 32'(rdy_a), 1);

    chk("no_contention_a", cont_a, 0);
    chk("no_contention_b", cont_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
